// File: rtl/mips_cpu_bus.sv
// Multi-cycle MIPS-I subset core with a single Avalon-style read/write bus master port.
// Latency: five cycles per instruction (FETCH..WRITE_BACK) plus any waitrequest stall cycles.
// Backpressure: waitrequest holds FETCH or MEMORY_ACCESS with address and strobes unchanged.
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [2:0]  state_pass_to_testbench
);

  typedef enum logic [2:0] {
    FETCH         = 3'd0,
    DECODE        = 3'd1,
    EXECUTE       = 3'd2,
    MEMORY_ACCESS = 3'd3,
    WRITE_BACK    = 3'd4,
    HALTED        = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, ir, a, b, imm_ext, alu_out, mdr;
  logic [31:0] regs [32];
  logic        br_take, pending;
  logic [31:0] br_target, pending_target;
  logic [31:0] alu_res, target, pc_next, wb_data;
  logic        take, wb_en;
  logic [4:0]  wb_addr;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] pc_plus4;
  logic        is_lw, is_sw;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);

  // A pending delay-slot target overrides sequential flow once the slot completes.
  assign pc_next = pending ? pending_target : pc_plus4;
  assign wb_data = is_lw ? mdr : alu_out;

  assign register_v0             = regs[2];
  assign writedata               = b;
  assign byteenable              = 4'b1111;
  assign state_pass_to_testbench = state;

  // ALU result, branch decision and branch/jump target for the instruction in IR.
  always_comb begin
    alu_res = 32'h0;
    take    = 1'b0;
    target  = pc_plus4 + (imm_ext << 2);
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21: alu_res = a + b;
          6'h23: alu_res = a - b;
          6'h24: alu_res = a & b;
          6'h25: alu_res = a | b;
          6'h26: alu_res = a ^ b;
          6'h2A: alu_res = {31'b0, $signed(a) < $signed(b)};
          6'h2B: alu_res = {31'b0, a < b};
          6'h08: begin
            take   = 1'b1;
            target = a;
          end
          default: alu_res = 32'h0;
        endcase
      end
      6'h02: begin
        take   = 1'b1;
        target = {pc_plus4[31:28], ir[25:0], 2'b00};
      end
      6'h04: take = (a == b);
      6'h05: take = (a != b);
      6'h09, 6'h23, 6'h2B: alu_res = a + imm_ext;
      6'h0A: alu_res = {31'b0, $signed(a) < $signed(imm_ext)};
      6'h0B: alu_res = {31'b0, a < imm_ext};
      6'h0C: alu_res = a & imm_ext;
      6'h0D: alu_res = a | imm_ext;
      6'h0E: alu_res = a ^ imm_ext;
      6'h0F: alu_res = {ir[15:0], 16'h0};
      default: alu_res = 32'h0;
    endcase
  end

  // Destination register selection; unsupported encodings write nothing.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rd;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B: wb_en = 1'b1;
          default: wb_en = 1'b0;
        endcase
      end
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
        wb_en   = 1'b1;
        wb_addr = rt;
      end
      default: wb_en = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Next state and bus strobes; FETCH waits for active so no read is issued during reset.
  always_comb begin
    state_next = state;
    read       = 1'b0;
    write      = 1'b0;
    address    = pc;
    case (state)
      FETCH: begin
        read = active;
        if (active && !waitrequest) state_next = DECODE;
      end
      DECODE:  state_next = EXECUTE;
      EXECUTE: state_next = MEMORY_ACCESS;
      MEMORY_ACCESS: begin
        address = {alu_out[31:2], 2'b00};
        if (is_lw || is_sw) begin
          read  = is_lw;
          write = is_sw;
          if (!waitrequest) state_next = WRITE_BACK;
        end else begin
          state_next = WRITE_BACK;
        end
      end
      WRITE_BACK: state_next = (pc_next == 32'h0) ? HALTED : FETCH;
      HALTED:     state_next = HALTED;
      default:    state_next = FETCH;
    endcase
  end

  // Datapath registers, PC and delay-slot bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active         <= 1'b0;
      pc             <= RESET_VECTOR;
      ir             <= 32'h0;
      a              <= 32'h0;
      b              <= 32'h0;
      imm_ext        <= 32'h0;
      alu_out        <= 32'h0;
      mdr            <= 32'h0;
      br_take        <= 1'b0;
      br_target      <= 32'h0;
      pending        <= 1'b0;
      pending_target <= 32'h0;
    end else begin
      active <= (state_next != HALTED);
      case (state)
        FETCH: if (active && !waitrequest) ir <= readdata;
        DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
          if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
            imm_ext <= {16'h0, ir[15:0]};
          else
            imm_ext <= {{16{ir[15]}}, ir[15:0]};
        end
        EXECUTE: begin
          alu_out   <= alu_res;
          br_take   <= take;
          br_target <= target;
        end
        MEMORY_ACCESS: if (is_lw && !waitrequest) mdr <= readdata;
        WRITE_BACK: begin
          pc             <= pc_next;
          pending        <= br_take;
          pending_target <= br_target;
        end
        default: ;
      endcase
    end
  end

  // Register file; $0 stays zero because writes to it are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (state == WRITE_BACK && wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus.sv
module tb_mips_cpu_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic [2:0]  state;

  logic [31:0] rom [64];
  logic [31:0] ram [64];
  int          wr_count = 0;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;

  int errors = 0;
  int checks = 0;
  int cycles = 0;

  always #5 clk = ~clk;

  mips_cpu_bus dut (
    .clk                     (clk),
    .reset                   (reset),
    .active                  (active),
    .register_v0             (register_v0),
    .address                 (address),
    .write                   (write),
    .read                    (read),
    .waitrequest             (waitrequest),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .readdata                (readdata),
    .state_pass_to_testbench (state)
  );

  // Boot ROM at 0xBFC00000, data RAM at 0x00001000.
  assign readdata = (address[31:8] == 24'hBFC000) ? rom[address[7:2]] :
                    (address[31:8] == 24'h000010) ? ram[address[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (write && !waitrequest) begin
      wr_count <= wr_count + 1;
      wr_addr  <= address;
      wr_data  <= writedata;
      wr_be    <= byteenable;
      if (address[31:8] == 24'h000010) ram[address[7:2]] <= writedata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic load6(input logic [31:0] i0, i1, i2, i3, i4, i5);
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = i0; rom[1] = i1; rom[2] = i2;
    rom[3] = i3; rom[4] = i4; rom[5] = i5;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    cycles = 0;
  endtask

  task automatic run_to_halt(input int limit);
    while (state !== 3'd5 && cycles < limit) tick();
    check("halt_reached", {29'b0, state}, 32'd5);
  endtask

  initial begin
    int w0;
    bit found;

    // Program 1: ADDIU $2,$0,5; ADDIU $2,$2,-1; JR $0; NOP
    load6(32'h24020005, 32'h2442FFFF, 32'h00000008, 32'h00000000, 32'h0, 32'h0);
    reset       = 1'b0;
    waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_active", {31'b0, active}, 32'd0);
    check("rst_read",   {31'b0, read},   32'd0);
    check("rst_write",  {31'b0, write},  32'd0);
    check("rst_be",     {28'b0, byteenable}, 32'hF);
    check("rst_state",  {29'b0, state},  32'd0);
    reset  = 1'b1;
    cycles = 0;
    tick();
    check("boot_active", {31'b0, active}, 32'd1);
    check("boot_state",  {29'b0, state},  32'd0);
    check("boot_read",   {31'b0, read},   32'd1);
    check("boot_addr",   address,         32'hBFC00000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("state_seq", {29'b0, state}, 32'(k % 5));
    end
    run_to_halt(200);
    check("p1_cycles", 32'(cycles), 32'd21);
    check("p1_v0",     register_v0, 32'h00000004);
    check("p1_active", {31'b0, active}, 32'd0);
    tick();
    tick();
    check("halt_read",  {31'b0, read},  32'd0);
    check("halt_write", {31'b0, write}, 32'd0);
    check("halt_stay",  {29'b0, state}, 32'd5);

    // Program 2: LUI/ORI build 0x12345678, store to 0x1000, load into $2
    load6(32'h3C031234, 32'h34635678, 32'hAC031000, 32'h8C021000, 32'h00000008, 32'h00000000);
    do_reset();
    w0 = wr_count;
    run_to_halt(200);
    check("p2_wr_count", 32'(wr_count - w0), 32'd1);
    check("p2_wr_addr",  wr_addr, 32'h00001000);
    check("p2_wr_data",  wr_data, 32'h12345678);
    check("p2_wr_be",    {28'b0, wr_be}, 32'hF);
    check("p2_v0",       register_v0, 32'h12345678);
    check("p2_cycles",   32'(cycles), 32'd31);

    // Program 3: BEQ with delay slot; skipped instruction must not execute
    load6(32'h10000002, 32'h24020001, 32'h24420064, 32'h2442000A, 32'h00000008, 32'h00000000);
    do_reset();
    run_to_halt(200);
    check("p3_v0",     register_v0, 32'h0000000B);
    check("p3_cycles", 32'(cycles), 32'd26);

    // Program 2 again with three stall cycles on a fetch and on the LW
    load6(32'h3C031234, 32'h34635678, 32'hAC031000, 32'h8C021000, 32'h00000008, 32'h00000000);
    do_reset();
    found = 1'b0;
    while (!found && cycles < 100) begin
      tick();
      if (state == 3'd0 && read && address == 32'hBFC00004) found = 1'b1;
    end
    check("ws_fetch_found", {31'b0, found}, 32'd1);
    waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ws_fetch_state", {29'b0, state}, 32'd0);
      check("ws_fetch_read",  {31'b0, read},  32'd1);
      check("ws_fetch_addr",  address, 32'hBFC00004);
    end
    waitrequest = 1'b0;
    found = 1'b0;
    while (!found && cycles < 100) begin
      tick();
      if (state == 3'd3 && read) found = 1'b1;
    end
    check("ws_lw_found", {31'b0, found}, 32'd1);
    waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ws_lw_state", {29'b0, state}, 32'd3);
      check("ws_lw_read",  {31'b0, read},  32'd1);
      check("ws_lw_addr",  address, 32'h00001000);
    end
    waitrequest = 1'b0;
    run_to_halt(200);
    check("ws_v0",     register_v0, 32'h12345678);
    check("ws_cycles", 32'(cycles), 32'd37);

    // Reset asserted while the SW is on the bus
    do_reset();
    found = 1'b0;
    while (!found && cycles < 100) begin
      tick();
      if (state == 3'd3 && write) found = 1'b1;
    end
    check("rs_sw_found", {31'b0, found}, 32'd1);
    w0 = wr_count;
    #2;
    reset = 1'b0;
    #1;
    check("rs_write",  {31'b0, write},  32'd0);
    check("rs_read",   {31'b0, read},   32'd0);
    check("rs_active", {31'b0, active}, 32'd0);
    check("rs_state",  {29'b0, state},  32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    cycles = 0;
    tick();
    check("rs_wr_lost",   32'(wr_count - w0), 32'd0);
    check("rs_active_up", {31'b0, active}, 32'd1);
    check("rs_boot_addr", address, 32'hBFC00000);
    check("rs_boot_read", {31'b0, read}, 32'd1);
    check("rs_v0_zero",   register_v0, 32'h0);
    run_to_halt(200);
    check("rs_final_v0", register_v0, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus.md
Name: mips_cpu_bus

Overview:
- Multi-cycle MIPS-I subset CPU (32-bit) with a single memory-mapped bus master port, Avalon-style read/write/waitrequest.
- Executes from the reset vector until it jumps to address 0, then halts and drops active.
- Exposes $v0 and the FSM state for system-level benches.
- Sits between the system bus/RAM model and the test harness.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- active  out  1  high while executing; low in reset and after halt
- register_v0  out  32  live contents of GPR $2
- address  out  32  byte address, always word aligned (bits[1:0]=0)
- write  out  1  bus write strobe
- read  out  1  bus read strobe
- waitrequest  in  1  slave stall; holds the current transfer
- writedata  out  32  store data, byte lane i = address+i (little-endian)
- byteenable  out  4  lane enables; 4'b1111 for all supported accesses
- readdata  in  32  load/fetch data, same lane order as writedata
- state_pass_to_testbench  out  3  current FSM state code

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_VECTOR, all 32 GPRs=0, state=FETCH, active=0.
  - read=write=0, byteenable=4'b1111.
- First rising edge after reset is released: active=1.
- FSM codes:
  - 0 FETCH
  - 1 DECODE
  - 2 EXECUTE
  - 3 MEMORY_ACCESS
  - 4 WRITE_BACK
  - 5 HALTED
- Every instruction visits 0→1→2→3→4 in order. Instruction completes in WRITE_BACK, then returns to FETCH. Minimum 5 cycles per instruction.
- FETCH:
  - read=1, address=PC.
  - Stay while waitrequest=1.
  - Latch readdata into IR when waitrequest=0.
- DECODE: read rs/rt, sign- or zero-extend imm16.
- EXECUTE: ALU op, branch compare, target calculation.
- MEMORY_ACCESS:
  - LW: read=1, address=ALU result.
  - SW: write=1, writedata=rt.
  - Hold while waitrequest=1.
  - Other opcodes: no bus activity.
- WRITE_BACK:
  - Register file write; $0 writes are ignored.
  - PC update.
- read and write are never asserted together. Both are 0 outside FETCH and MEMORY_ACCESS.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, JR.
  - I-type: ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU, LW, SW, BEQ, BNE.
  - J-type: J.
  - Unsupported opcodes execute as NOP.
- Arithmetic rules:
  - 32-bit wrap-around, no overflow traps.
  - ANDI/ORI/XORI zero-extend the immediate. All others sign-extend.
  - SLT is signed; SLTU is unsigned.
- Branch delay slot:
  - A taken branch or jump sets a pending target.
  - The following instruction (delay slot) always executes, then PC=target.
  - BEQ/BNE target = PC_of_branch + 4 + (sext(imm16)<<2).
  - J target = {PC+4[31:28], imm26, 2'b00}.
  - JR target = rs.
- Halt:
  - When the PC about to be fetched equals 32'h0, enter HALTED instead of FETCH.
  - In HALTED, active=0 and there is no bus activity.
  - HALTED is left only via reset.
  - The delay slot of a JR $0 executes before the halt.
- register_v0 reflects $2 combinationally from the register file. It is valid in HALTED.
- Reset mid-transfer: the transfer is abandoned immediately and strobes drop. The core restarts from RESET_VECTOR.
- Misaligned LW/SW: the address is forced to a word boundary (bits[1:0] cleared). No exception is raised.

Test Plan:
- Reset release → active=1 within one cycle; first bus read at address 32'hBFC00000 with state=0; state sequence 0,1,2,3,4,0.
- Program: ADDIU $2,$0,5; ADDIU $2,$2,-1; JR $0; NOP → active falls to 0, register_v0=32'h00000004, state=5.
- Program: LUI $3,0x1234; ORI $3,$3,0x5678; SW $3,0($0+base); LW $2,0(base); JR $0; NOP → write at base with writedata=32'h12345678, byteenable=4'hF; final register_v0=32'h12345678.
- BEQ $0,$0,+2 with ADDIU $2,$0,1 in the delay slot and ADDIU $2,$2,10 at the target → delay slot executes, skipped instruction does not; register_v0=32'h0000000B.
- Hold waitrequest=1 for 3 cycles during FETCH and during a LW → address, read and state are held; the instruction completes with the correct result; total cycles increase by exactly 6.
- Assert reset during MEMORY_ACCESS of a SW → write drops immediately, active=0; after release, execution restarts at RESET_VECTOR with $2=0.
